// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding read, valid/ready to decode, redirect flush.
// Define IFU_PERF_CNT_EN to add the fetch/stall/flush performance counters.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_rsp_valid,
    output logic        o_mem_rsp_ready,
    input  logic [31:0] i_mem_rsp_data,
    input  logic        i_mem_rsp_err,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic        o_fetch_err,
    output logic        o_valid,
    input  logic        i_ready
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [63:0] o_perf_fetch_cnt,
    output logic [63:0] o_perf_stall_cnt,
    output logic [31:0] o_perf_flush_cnt
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FLUSH
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_out_pc;
    logic [31:0] r_out_inst;
    logic        r_out_err;
    logic        r_valid;
    logic        w_valid_nxt;
    logic        w_capture;
    logic [31:0] w_redir_pc;
    logic        w_req_hs;
    logic        w_rsp_hs;
    logic        w_fire;

    assign w_redir_pc      = i_redirect_pc & ~32'h3;
    assign o_mem_req_valid = i_rst & (r_state == S_REQ);
    assign o_mem_rsp_ready = i_rst & ((r_state == S_WAIT) | (r_state == S_FLUSH));
    assign o_mem_addr      = r_pc;
    assign w_req_hs        = o_mem_req_valid & i_mem_req_ready;
    assign w_rsp_hs        = o_mem_rsp_ready & i_mem_rsp_valid;
    // A redirect kills the presented instruction in the same cycle.
    assign o_valid         = r_valid & ~i_redirect_valid;
    assign w_fire          = o_valid & i_ready;
    assign o_pc            = r_out_pc;
    assign o_inst          = r_out_inst;
    assign o_fetch_err     = r_out_err;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_valid_nxt = r_valid;
        w_capture   = 1'b0;
        unique case (r_state)
            S_REQ: begin
                if (i_redirect_valid) begin
                    w_pc_nxt = w_redir_pc;
                    if (w_req_hs) w_state_nxt = S_FLUSH;
                end else if (w_req_hs) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_redirect_valid) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = w_rsp_hs ? S_REQ : S_FLUSH;
                end else if (w_rsp_hs) begin
                    w_capture   = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_redirect_valid) begin
                    w_pc_nxt    = w_redir_pc;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_REQ;
                end else if (w_fire) begin
                    w_pc_nxt    = r_pc + PC_STEP;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_REQ;
                end
            end
            S_FLUSH: begin
                if (i_redirect_valid) w_pc_nxt = w_redir_pc;
                if (w_rsp_hs) w_state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_valid    <= 1'b0;
            r_out_pc   <= RESET_PC;
            r_out_inst <= NOP;
            r_out_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_valid <= w_valid_nxt;
            if (w_capture) begin
                r_out_pc   <= r_pc;
                r_out_inst <= i_mem_rsp_err ? NOP : i_mem_rsp_data;
                r_out_err  <= i_mem_rsp_err;
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [63:0] r_fetch_cnt;
    logic [63:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_stall;
    logic        w_flush_entry;

    assign w_stall       = (r_state == S_REQ) | (r_state == S_WAIT);
    assign w_flush_entry = i_redirect_valid &
                           (((r_state == S_REQ) & w_req_hs) |
                            ((r_state == S_WAIT) & ~w_rsp_hs));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_fire && r_fetch_cnt != '1) r_fetch_cnt <= r_fetch_cnt + 64'd1;
            if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 64'd1;
            if (w_flush_entry && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign o_perf_fetch_cnt = r_fetch_cnt;
    assign o_perf_stall_cnt = r_stall_cnt;
    assign o_perf_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch against a transaction-level fetch model.
// Performance counters are checked when IFU_PERF_CNT_EN is defined.
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic [31:0] o_mem_addr;
    logic        i_mem_rsp_valid;
    logic        o_mem_rsp_ready;
    logic [31:0] i_mem_rsp_data;
    logic        i_mem_rsp_err;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic        o_fetch_err;
    logic        o_valid;
    logic        i_ready;
`ifdef IFU_PERF_CNT_EN
    logic [63:0] o_perf_fetch_cnt;
    logic [63:0] o_perf_stall_cnt;
    logic [31:0] o_perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    ifu_fetch dut (
        .i_clk            (clk),
        .i_rst            (i_rst),
        .o_mem_req_valid  (o_mem_req_valid),
        .i_mem_req_ready  (i_mem_req_ready),
        .o_mem_addr       (o_mem_addr),
        .i_mem_rsp_valid  (i_mem_rsp_valid),
        .o_mem_rsp_ready  (o_mem_rsp_ready),
        .i_mem_rsp_data   (i_mem_rsp_data),
        .i_mem_rsp_err    (i_mem_rsp_err),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_pc             (o_pc),
        .o_inst           (o_inst),
        .o_fetch_err      (o_fetch_err),
        .o_valid          (o_valid),
        .i_ready          (i_ready)
`ifdef IFU_PERF_CNT_EN
        ,
        .o_perf_fetch_cnt (o_perf_fetch_cnt),
        .o_perf_stall_cnt (o_perf_stall_cnt),
        .o_perf_flush_cnt (o_perf_flush_cnt)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } ent_t;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: instructions awaiting acceptance, next fetch pc,
    // the single outstanding memory read and whether it went stale.
    ent_t        q[$];
    logic [31:0] mpc;
    logic [31:0] req_addr;
    bit          outst;
    bit          stale;
    int          lat;
    longint      n_fetch;
    longint      n_stall;
    longint      n_flush;

    int p_redir;
    int p_rdy;
    int p_mrdy;
    int max_lat;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mpc     = RST_PC;
        outst   = 0;
        stale   = 0;
        lat     = 0;
        n_fetch = 0;
        n_stall = 0;
        n_flush = 0;
    endtask

    task automatic drive();
        i_rst            = 1'b1;
        i_redirect_valid = ($urandom_range(99) < p_redir);
        i_redirect_pc    = $urandom;
        i_ready          = ($urandom_range(99) < p_rdy);
        i_mem_req_ready  = ($urandom_range(99) < p_mrdy);
        i_mem_rsp_valid  = 1'b0;
        i_mem_rsp_data   = $urandom;
        i_mem_rsp_err    = 1'b0;
        if (outst) begin
            if (lat == 0) begin
                i_mem_rsp_valid = 1'b1;
                i_mem_rsp_err   = ($urandom_range(7) == 0);
            end else begin
                lat--;
            end
        end else if ($urandom_range(19) == 0) begin
            // Spurious response with nothing outstanding must be ignored.
            i_mem_rsp_valid = 1'b1;
            i_mem_rsp_data  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic step();
        bit exp_req;
        bit hs_req;
        bit hs_rsp;
        bit fire;
        @(negedge clk);
        drive();
        #1;
        exp_req = !outst && q.size() == 0;
        chk("req_valid", o_mem_req_valid, exp_req);
        chk("rsp_ready", o_mem_rsp_ready, outst);
        chk("o_valid", o_valid, q.size() > 0 && !i_redirect_valid);
        if (o_valid && q.size() > 0) begin
            chk("o_pc", o_pc, q[0].pc);
            chk("o_inst", o_inst, q[0].inst);
            chk("o_fetch_err", o_fetch_err, q[0].err);
        end
        hs_req = o_mem_req_valid && i_mem_req_ready;
        hs_rsp = outst && i_mem_rsp_valid && o_mem_rsp_ready;
        fire   = o_valid && i_ready;
        if (hs_req) chk("req_addr", o_mem_addr, mpc);
        if (exp_req || (outst && !stale)) n_stall++;
        if (i_redirect_valid && (hs_req || (outst && !stale && !hs_rsp)))
            n_flush++;
        if (hs_rsp) begin
            if (!stale && !i_redirect_valid)
                q.push_back('{req_addr,
                              i_mem_rsp_err ? NOP : i_mem_rsp_data,
                              i_mem_rsp_err});
            outst = 0;
            stale = 0;
        end
        if (fire && q.size() > 0) begin
            void'(q.pop_front());
            mpc = mpc + 32'd4;
            n_fetch++;
        end
        if (hs_req) begin
            outst    = 1;
            stale    = 0;
            req_addr = mpc;
            lat      = $urandom_range(max_lat);
        end
        if (i_redirect_valid) begin
            mpc = {i_redirect_pc[31:2], 2'b00};
            q.delete();
            if (outst) stale = 1;
        end
    endtask

    task automatic do_reset(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_rst            = 1'b0;
            i_mem_req_ready  = 1'b1;
            i_mem_rsp_valid  = 1'b0;
            i_mem_rsp_data   = 32'h0;
            i_mem_rsp_err    = 1'b0;
            i_redirect_valid = 1'b0;
            i_redirect_pc    = 32'h0;
            i_ready          = 1'b1;
            #1;
            chk("rst_req_valid", o_mem_req_valid, 1'b0);
            chk("rst_rsp_ready", o_mem_rsp_ready, 1'b0);
        end
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_o_pc", o_pc, RST_PC);
        chk("rst_o_inst", o_inst, NOP);
        chk("rst_o_fetch_err", o_fetch_err, 1'b0);
`ifdef IFU_PERF_CNT_EN
        chk("rst_perf_fetch", o_perf_fetch_cnt, 64'd0);
        chk("rst_perf_stall", o_perf_stall_cnt, 64'd0);
        chk("rst_perf_flush", o_perf_flush_cnt, 64'd0);
`endif
        model_reset();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int k;
        model_reset();
        do_reset(3);

        p_redir = 0;
        p_rdy   = 100;
        p_mrdy  = 100;
        max_lat = 0;
        run(30);

        p_redir = 8;
        p_rdy   = 60;
        p_mrdy  = 70;
        max_lat = 3;
        run(3000);

        k = 0;
        while (!(outst && !stale) && k < 50) begin
            step();
            k++;
        end
        chk("reach_wait", outst && !stale, 1'b1);
        do_reset(2);

        p_rdy = 40;
        run(2000);

`ifdef IFU_PERF_CNT_EN
        #1;
        chk("perf_fetch", o_perf_fetch_cnt, n_fetch);
        chk("perf_stall", o_perf_stall_cnt, n_stall);
        chk("perf_flush", o_perf_flush_cnt, n_flush);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
